shift_deser: RTL

- Parametrised serial-to-parallel deserializer for the SPART receive path; successor to the fixed 8-bit shifter.
- Collects WIDTH data bits from a 1-bit stream when enabled, with optional parity bit and LSB- or MSB-first order.
- Double-buffered: the next word shifts in while the previous word waits for consumer acknowledge.
- Flags parity errors and overruns.

---
 rtl/shift_deser.sv | 108 ++++++++++
 1 files changed

// File: rtl/shift_deser.sv
// shift_deser: double-buffered serial-to-parallel deserializer with optional parity check
// and overrun detection; LSB- or MSB-first bit order.
module shift_deser #(
    parameter int WIDTH      = 8,
    parameter int LSB_FIRST  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nxt_bit,
    input  logic             en,
    input  logic             clr,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             has_data,
    output logic             parity_err,
    output logic             overrun
);
    typedef enum logic {SHIFT, PARITY} state_t;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, data_q, data_d, sh, word;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d, has_q, has_d, perr_q, perr_d, ovr_q, ovr_d;
    logic             done, err;

    assign sh = (LSB_FIRST != 0) ? {nxt_bit, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], nxt_bit};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        data_d  = data_q;
        has_d   = has_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        done    = 1'b0;
        word    = sh;
        err     = 1'b0;
        if (has_q && ack) has_d = 1'b0;
        if (clr) begin
            state_d = SHIFT;
            sreg_d  = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
            ovr_d   = 1'b0;
        end else if (en) begin
            if (state_q == SHIFT) begin
                sreg_d = sh;
                par_d  = par_q ^ nxt_bit;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (PARITY_EN != 0) state_d = PARITY;
                    else done = 1'b1;
                end
            end else begin
                done = 1'b1;
                word = sreg_q;
                err  = (par_q ^ nxt_bit) != PARITY_ODD[0];
            end
            // A completed word lands only if the output buffer is free or being freed now
            if (done) begin
                cnt_d   = '0;
                par_d   = 1'b0;
                state_d = SHIFT;
                if (!has_q || ack) begin
                    data_d = word;
                    perr_d = err;
                    has_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SHIFT;
            sreg_q  <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            has_q   <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            data_q  <= data_d;
            has_q   <= has_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign has_data   = has_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
endmodule
